// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one 32-bit SRAM port between the AHB-SRAM bridge and a secondary
//   master (DMA/loader). The bridge always wins and sees zero added latency.
//   The secondary master gets the port only in cycles the bridge leaves idle.
//   An optional post-reset zero-fill runs before any secondary grant. It is
//   enabled by defining the macro SRAM_ARB_INIT_CLEAR_EN. When the macro is
//   undefined, init_done is a constant 1.
module sram_port_arbiter #(
  parameter int ADDR_W      = 15,
  parameter int DEPTH_WORDS = 8192,
  parameter int WAIT_W      = 8,
  parameter int STARVE_LIM  = 64
) (
  input  logic              HCLK,
  input  logic              HRESET,
  // bridge side
  input  logic              b_cs,
  input  logic [3:0]        b_wen,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic [31:0]       b_rdata,
  // secondary master side
  input  logic              s_req,
  input  logic [3:0]        s_wen,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [31:0]       s_wdata,
  output logic              s_gnt,
  output logic              s_rvalid,
  output logic [31:0]       s_rdata,
  output logic              s_starved,
  output logic              init_done,
  // SRAM macro side
  output logic              ram_cs,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [WAIT_W-1:0] WAIT_MAX   = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] STARVE_THR = WAIT_W'(STARVE_LIM);

  // Catch an impossible configuration at elaboration time rather than in silicon.
  if (DEPTH_WORDS < 1 || DEPTH_WORDS > (2 ** ADDR_W) || STARVE_LIM >= (2 ** WAIT_W)) begin : g_cfg_check
    $error("sram_port_arbiter: illegal DEPTH_WORDS/STARVE_LIM for ADDR_W/WAIT_W");
  end

  logic              clr_active;  // the zero-fill owns the port this cycle
  logic [ADDR_W-1:0] clr_addr;    // word being zero-filled this cycle

`ifdef SRAM_ARB_INIT_CLEAR_EN
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W-1:0] CLR_ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  // The fill only uses cycles the bridge leaves free. It is held off while reset is asserted.
  assign clr_active = (state_q == ST_CLEAR) & ~b_cs & ~HRESET;
  assign clr_addr   = clr_addr_q;
  assign init_done  = (state_q == ST_DONE) & ~HRESET;

  // Next-state logic for the zero-fill: advance one word per free cycle and stop after the last word.
  always_comb begin
    // NOTE: every signal assigned here gets a default first. A path that leaves
    // one unassigned would make synthesis infer a latch.
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (clr_active) begin
      if (clr_addr_q == CLR_LAST) begin
        state_d = ST_DONE;
      end else begin
        clr_addr_d = clr_addr_q + CLR_ONE;
      end
    end
  end

  // Zero-fill state register. Every reset restarts the fill from word 0.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end
`else
  assign clr_active = 1'b0;
  assign clr_addr   = '0;
  assign init_done  = 1'b1;
`endif

  // A grant is never issued while the bridge, an unfinished fill or reset holds the port.
  assign s_gnt = s_req & ~b_cs & init_done & ~HRESET;

  // Port mux with fixed priority: bridge, then zero-fill, then secondary. An idle port drives all zeros.
  always_comb begin
    ram_cs    = 1'b0;
    ram_wen   = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    if (b_cs) begin
      ram_cs    = 1'b1;
      ram_wen   = b_wen;
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
    end else if (clr_active) begin
      ram_cs    = 1'b1;
      ram_wen   = 4'b1111;
      ram_addr  = clr_addr;
      ram_wdata = '0;
    end else if (s_gnt) begin
      ram_cs    = 1'b1;
      ram_wen   = s_wen;
      ram_addr  = s_addr;
      ram_wdata = s_wdata;
    end
  end

  // SRAM read data lands one cycle after the select. Both masters see the same bus.
  assign b_rdata = ram_rdata;
  assign s_rdata = ram_rdata;

  logic              rvalid_q, rvalid_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  // A granted read returns data next cycle. Writes produce no response.
  assign rvalid_d = s_gnt & (s_wen == 4'b0000);

  // Count consecutive cycles the secondary is kept waiting. The count saturates instead of wrapping.
  always_comb begin
    wait_d = wait_q;
    if (!s_req || s_gnt) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + WAIT_ONE;
    end
  end

  // Starvation is only reported for visibility. It never throttles the bridge.
  assign s_starved = (wait_q >= STARVE_THR);
  assign s_rvalid  = rvalid_q;

  // Response and wait-count registers. Reset drops a pending rvalid.
  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments only. Then every
    // register samples values from before the edge, whatever order the blocks run in.
    if (HRESET) begin
      rvalid_q <= 1'b0;
      wait_q   <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      wait_q   <= wait_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   The driver issues per-cycle stimulus and updates a transaction-level
//   reference model. The model is a word array, a wait-cycle count and a
//   fill pointer. For each cycle the driver pushes the expected bus/grant
//   values and any expected read data into queues. A separate monitor pops
//   those entries and compares them with the DUT outputs.
module tb_sram_port_arbiter;

  localparam int ADDR_W     = 8;
  localparam int DEPTH      = 16;
  localparam int WAIT_W     = 8;
  localparam int STARVE_LIM = 64;
  localparam int WAIT_SAT   = (1 << WAIT_W) - 1;
  localparam int WORDS      = 1 << ADDR_W;
`ifdef SRAM_ARB_INIT_CLEAR_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              b_cs;
  logic [3:0]        b_wen;
  logic [ADDR_W-1:0] b_addr;
  logic [31:0]       b_wdata;
  logic [31:0]       b_rdata;
  logic              s_req;
  logic [3:0]        s_wen;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata;
  logic              s_gnt;
  logic              s_rvalid;
  logic [31:0]       s_rdata;
  logic              s_starved;
  logic              init_done;
  logic              ram_cs;
  logic [3:0]        ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  sram_port_arbiter #(
    .ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .WAIT_W(WAIT_W), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .b_cs(b_cs), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata),
    .s_req(s_req), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_starved(s_starved),
    .init_done(init_done),
    .ram_cs(ram_cs), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h0101_0137) ^ 32'h5A00_0000;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [3:0] wen, logic [31:0] d);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (wen[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Behavioural SRAM macro: synchronous, byte-writable, one-cycle read latency.
  logic [31:0] sram [WORDS];
  logic [31:0] sram_rd_q;
  logic        sram_loaded = 1'b0;
  always @(posedge HCLK) begin
    if (!sram_loaded) begin
      for (int i = 0; i < WORDS; i++) sram[i] <= init_word(i);
      sram_loaded <= 1'b1;
    end else if (ram_cs) begin
      if (ram_wen == 4'b0000) sram_rd_q <= sram[ram_addr];
      else                    sram[ram_addr] <= merge(sram[ram_addr], ram_wen, ram_wdata);
    end
  end
  assign ram_rdata = sram_rd_q;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_exp_t;

  typedef struct {
    logic        rst;
    logic [44:0] bus;
    logic        gnt;
    logic        starved;
    logic        init;
  } cyc_exp_t;

  rd_exp_t  sq[$];   // expected secondary read data
  rd_exp_t  bq[$];   // expected bridge read data
  cyc_exp_t cq[$];   // expected per-cycle port/grant values

  // Reference model state
  logic [31:0] ref_mem [WORDS];
  int          waited   = 0;   // consecutive cycles the secondary has been refused
  int          clr      = 0;   // words zero-filled since the last reset
  logic        last_gnt = 1'b0;
  logic        stim_done = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle and advance the reference model.
  task automatic drive_cycle(input logic rst,
                             input logic bcs, input logic [3:0] bwen,
                             input logic [ADDR_W-1:0] baddr, input logic [31:0] bwd,
                             input logic sreq, input logic [3:0] swen,
                             input logic [ADDR_W-1:0] saddr, input logic [31:0] swd);
    cyc_exp_t e;
    logic     exp_init, exp_gnt, do_clr;
    @(negedge HCLK);
    HRESET = rst;
    b_cs = bcs; b_wen = bwen; b_addr = baddr; b_wdata = bwd;
    s_req = sreq; s_wen = swen; s_addr = saddr; s_wdata = swd;
    #1;
    exp_init = INIT_EN ? (!rst && clr == DEPTH) : 1'b1;
    exp_gnt  = sreq && !bcs && exp_init && !rst;
    do_clr   = INIT_EN && !rst && !bcs && clr < DEPTH;
    e.rst = rst; e.gnt = exp_gnt; e.init = exp_init;
    e.starved = (waited >= STARVE_LIM);
    e.bus = '0;
    if (bcs) begin
      e.bus = {1'b1, bwen, baddr, bwd};
      if (bwen == 4'b0000) bq.push_back('{cyc + 1, ref_mem[baddr]});
      else ref_mem[baddr] = merge(ref_mem[baddr], bwen, bwd);
    end else if (do_clr) begin
      e.bus = {1'b1, 4'b1111, ADDR_W'(clr), 32'h0};
      ref_mem[clr] = 32'h0;
    end else if (exp_gnt) begin
      e.bus = {1'b1, swen, saddr, swd};
      if (swen == 4'b0000) sq.push_back('{cyc + 1, ref_mem[saddr]});
      else ref_mem[saddr] = merge(ref_mem[saddr], swen, swd);
    end
    cq.push_back(e);
    if (rst || !sreq || exp_gnt) waited = 0;
    else if (waited < WAIT_SAT) waited = waited + 1;
    if (rst) clr = 0;
    else if (do_clr) clr = clr + 1;
    last_gnt = exp_gnt;
  endtask

  task automatic idle(input logic sreq, input logic [3:0] swen, input logic [ADDR_W-1:0] saddr,
                      input logic [31:0] swd);
    drive_cycle(1'b0, 1'b0, 4'h0, '0, 32'h0, sreq, swen, saddr, swd);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 4'h0, '0, 32'h0, 1'b0, 4'h0, '0, 32'h0);
  endtask

  // Monitor: consumes the scoreboard queues against what the DUT presents.
  initial begin : monitor
    rd_exp_t  r;
    cyc_exp_t c;
    forever begin
      @(negedge HCLK);
      if (s_rvalid === 1'b1) begin
        if (sq.size() == 0) check("s_rvalid_unexpected", 64'(s_rvalid), 64'd0);
        else begin
          r = sq.pop_front();
          check("s_rvalid_timing", 64'(cyc), 64'(r.due));
          check("s_rdata", 64'(s_rdata), 64'(r.data));
        end
      end else if (sq.size() > 0 && sq[0].due <= cyc) begin
        r = sq.pop_front();
        check("s_rvalid_missing", 64'(s_rvalid), 64'd1);
      end
      if (bq.size() > 0 && bq[0].due == cyc) begin
        r = bq.pop_front();
        check("b_rdata", 64'(b_rdata), 64'(r.data));
      end
      if (stim_done) break;
      #2;
      while (cq.size() > 0) begin
        c = cq.pop_front();
        check("ram_bus", 64'({ram_cs, ram_wen, ram_addr, ram_wdata}), 64'(c.bus));
        check("s_gnt", 64'(s_gnt), 64'(c.gnt));
        check("init_done", 64'(init_done), 64'(c.init));
        if (!c.rst) check("s_starved", 64'(s_starved), 64'(c.starved));
      end
    end
    check("s_rd_queue_drained", 64'(sq.size()), 64'd0);
    check("b_rd_queue_drained", 64'(bq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin : driver
    logic              pend, rst_r, bcs_r;
    logic [3:0]        pw, bw;
    logic [ADDR_W-1:0] pa;
    logic [31:0]       pd;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    HRESET = 1'b1; b_cs = 1'b0; b_wen = '0; b_addr = '0; b_wdata = '0;
    s_req = 1'b0; s_wen = '0; s_addr = '0; s_wdata = '0;
    reset_cycles(3);

    // Zero-fill with bridge cycles interleaved. The secondary request must wait for init_done.
    if (INIT_EN) begin
      for (int k = 0; k < 100 && clr < DEPTH; k++) begin
        if (k == 2 || k == 7 || k == 11)
          drive_cycle(1'b0, 1'b1, 4'h0, ADDR_W'(k), 32'h0, 1'b1, 4'h0, 8'h03, 32'h0);
        else idle(1'b1, 4'h0, 8'h03, 32'h0);
      end
      idle(1'b0, 4'h0, '0, 32'h0);
      for (int a = 0; a < DEPTH; a++) idle(1'b1, 4'h0, ADDR_W'(a), 32'h0);
    end

    // Secondary read on an idle port
    idle(1'b1, 4'h0, 8'h10, 32'h0);
    idle(1'b0, 4'h0, '0, 32'h0);

    // Bridge write collides with a secondary write. The secondary is granted next cycle.
    drive_cycle(1'b0, 1'b1, 4'hF, 8'h20, 32'hCAFE_0020, 1'b1, 4'hF, 8'h30, 32'hBEEF_0030);
    idle(1'b1, 4'hF, 8'h30, 32'hBEEF_0030);
    idle(1'b1, 4'h0, 8'h30, 32'h0);
    drive_cycle(1'b0, 1'b1, 4'h0, 8'h20, 32'h0, 1'b0, 4'h0, '0, 32'h0);

    // Partial-byte write over a known word, then read back
    drive_cycle(1'b0, 1'b1, 4'hF, 8'h05, 32'h1122_3344, 1'b0, 4'h0, '0, 32'h0);
    idle(1'b1, 4'b0011, 8'h05, 32'hAABB_CCDD);
    idle(1'b1, 4'h0, 8'h05, 32'h0);

    // Bridge holds the port for 70 cycles. Starvation must appear, then clear on the grant.
    for (int k = 0; k < 70; k++)
      drive_cycle(1'b0, 1'b1, 4'h0, ADDR_W'($urandom_range(0, 63)), 32'h0, 1'b1, 4'h0, 8'h40, 32'h0);
    idle(1'b1, 4'h0, 8'h40, 32'h0);
    idle(1'b0, 4'h0, '0, 32'h0);

    // Reset with a read response in flight, and a request presented during reset
    idle(1'b1, 4'h0, 8'h10, 32'h0);
    drive_cycle(1'b1, 1'b0, 4'h0, '0, 32'h0, 1'b1, 4'h0, 8'h11, 32'h0);
    idle(1'b0, 4'h0, '0, 32'h0);
    if (INIT_EN) begin
      for (int k = 0; k < 100 && clr < 8; k++) idle(1'b1, 4'h0, 8'h09, 32'h0);
      drive_cycle(1'b1, 1'b0, 4'h0, '0, 32'h0, 1'b1, 4'h0, 8'h09, 32'h0);
      for (int k = 0; k < 100 && clr < DEPTH; k++) idle(1'b1, 4'h0, 8'h09, 32'h0);
      idle(1'b0, 4'h0, '0, 32'h0);
    end

    // Randomised traffic: the secondary request is held stable until granted
    pend = 1'b0; pw = '0; pa = '0; pd = '0;
    for (int n = 0; n < 800; n++) begin
      rst_r = ($urandom_range(0, 299) == 0);
      bcs_r = ($urandom_range(0, 9) < 4);
      bw    = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        pa   = ADDR_W'($urandom_range(0, 31));
        pw   = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
        pd   = $urandom;
      end
      drive_cycle(rst_r, bcs_r, bw, ADDR_W'($urandom_range(0, 31)), $urandom, pend, pw, pa, pd);
      if (last_gnt) pend = 1'b0;
    end

    for (int k = 0; k < 4; k++) idle(1'b0, 4'h0, '0, 32'h0);
    stim_done = 1'b1;
  end

endmodule
